// File: rtl/seq_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_playback_ctrl
// Purpose  : Selects a sequence index with two debounced-by-sync pushbuttons,
//            fetches that sequence's directory entry (start, length, valid)
//            and steps a pattern ROM address through the sequence on every
//            step_tick, wrapping back to the start at the end.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK_50       in   1   system clock, rising edge active
//   reset        in   1   asynchronous active-high reset
//   pb_seq_up    in   1   raw pushbutton, next sequence
//   pb_seq_dn    in   1   raw pushbutton, previous sequence
//   step_tick    in   1   one-cycle step enable
//   dir_rd_addr  out  6   directory RAM read address (= seq_num)
//   dir_rd_data  in   32  directory entry, 1-cycle read latency
//                         [9:0] start, [19:10] length, [31] valid
//   rom_addr     out  10  pattern ROM address of current step
//   seq_num      out  6   selected sequence index
//   load         out  1   pulse: rom_addr holds a new step
//   at_end       out  1   pulse: this load wrapped back to start
//   playing      out  1   high while in PLAY
// ============================================================================
module seq_playback_ctrl #(
    parameter int PB_SYNC_STAGES = 2
) (
    input  logic        CLK_50,
    input  logic        reset,
    input  logic        pb_seq_up,
    input  logic        pb_seq_dn,
    input  logic        step_tick,
    output logic [5:0]  dir_rd_addr,
    input  logic [31:0] dir_rd_data,
    output logic [9:0]  rom_addr,
    output logic [5:0]  seq_num,
    output logic        load,
    output logic        at_end,
    output logic        playing
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LATCH = 2'd1,
        S_PLAY  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [PB_SYNC_STAGES-1:0] r_up_sync;
    logic [PB_SYNC_STAGES-1:0] r_dn_sync;
    logic                      r_up_prev;
    logic                      r_dn_prev;
    logic [5:0]                r_seq_num;
    logic [9:0]                r_rom_addr;
    logic [9:0]                r_start;
    logic [9:0]                r_length;
    logic [9:0]                r_step_cnt;
    logic                      r_load;
    logic                      r_at_end;

    logic w_up_ev;
    logic w_dn_ev;
    logic w_seq_change;
    logic w_entry_ok;
    logic w_unused_bits;

    // Rising edge of the last synchronizer stage gives a one-cycle event.
    assign w_up_ev      = r_up_sync[PB_SYNC_STAGES-1] & ~r_up_prev;
    assign w_dn_ev      = r_dn_sync[PB_SYNC_STAGES-1] & ~r_dn_prev;
    // Simultaneous up and down cancel out: no index change, no refetch.
    assign w_seq_change = w_up_ev ^ w_dn_ev;
    assign w_entry_ok   = dir_rd_data[31] && (dir_rd_data[19:10] != 10'd0);
    assign w_unused_bits = &{1'b0, dir_rd_data[30:20]};

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_up_sync  <= '0;
            r_dn_sync  <= '0;
            r_up_prev  <= 1'b0;
            r_dn_prev  <= 1'b0;
            r_seq_num  <= 6'd0;
            r_rom_addr <= 10'd0;
            r_start    <= 10'd0;
            r_length   <= 10'd0;
            r_step_cnt <= 10'd0;
            r_load     <= 1'b0;
            r_at_end   <= 1'b0;
        end else begin
            r_up_sync <= {r_up_sync[PB_SYNC_STAGES-2:0], pb_seq_up};
            r_dn_sync <= {r_dn_sync[PB_SYNC_STAGES-2:0], pb_seq_dn};
            r_up_prev <= r_up_sync[PB_SYNC_STAGES-1];
            r_dn_prev <= r_dn_sync[PB_SYNC_STAGES-1];
            r_load    <= 1'b0;
            r_at_end  <= 1'b0;

            if (w_seq_change) begin
                // A new selection aborts whatever is going on; a step_tick
                // arriving in this same cycle is deliberately dropped.
                r_seq_num <= w_up_ev ? r_seq_num + 6'd1 : r_seq_num - 6'd1;
                r_state   <= S_FETCH;
            end else begin
                case (r_state)
                    // Directory address already equals seq_num; this cycle
                    // just covers the RAM read latency.
                    S_FETCH: r_state <= S_LATCH;
                    S_LATCH: begin
                        r_start  <= dir_rd_data[9:0];
                        r_length <= dir_rd_data[19:10];
                        if (w_entry_ok) begin
                            r_rom_addr <= dir_rd_data[9:0];
                            r_step_cnt <= 10'd0;
                            r_load     <= 1'b1;
                            r_state    <= S_PLAY;
                        end else begin
                            r_state <= S_HALT;
                        end
                    end
                    S_PLAY: begin
                        if (step_tick) begin
                            r_load <= 1'b1;
                            if (r_step_cnt == r_length - 10'd1) begin
                                r_rom_addr <= r_start;
                                r_step_cnt <= 10'd0;
                                r_at_end   <= 1'b1;
                            end else begin
                                // 10-bit add rolls 1023 -> 0 naturally.
                                r_rom_addr <= r_rom_addr + 10'd1;
                                r_step_cnt <= r_step_cnt + 10'd1;
                            end
                        end
                    end
                    S_HALT:  r_state <= S_HALT;
                    default: r_state <= S_FETCH;
                endcase
            end
        end
    end

    assign dir_rd_addr = r_seq_num;
    assign seq_num     = r_seq_num;
    assign rom_addr    = r_rom_addr;
    assign load        = r_load;
    assign at_end      = r_at_end;
    assign playing     = (r_state == S_PLAY);

endmodule
`default_nettype wire

// File: tb/tb_seq_playback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_playback_ctrl
// Purpose  : Self-checking bench for seq_playback_ctrl. A behavioural
//            directory RAM answers reads; every expected load is queued as
//            {at_end, rom_addr} and popped when the DUT pulses load.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_playback_ctrl;

    localparam int PB = 2;

    logic        CLK_50 = 1'b0;
    logic        reset;
    logic        pb_seq_up;
    logic        pb_seq_dn;
    logic        step_tick;
    logic [5:0]  dir_rd_addr;
    logic [31:0] dir_rd_data;
    logic [9:0]  rom_addr;
    logic [5:0]  seq_num;
    logic        load;
    logic        at_end;
    logic        playing;

    logic [31:0] dir_mem [64];
    logic [10:0] sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          load_cnt = 0;
    int          snap;

    seq_playback_ctrl #(.PB_SYNC_STAGES(PB)) dut (
        .CLK_50      (CLK_50),
        .reset       (reset),
        .pb_seq_up   (pb_seq_up),
        .pb_seq_dn   (pb_seq_dn),
        .step_tick   (step_tick),
        .dir_rd_addr (dir_rd_addr),
        .dir_rd_data (dir_rd_data),
        .rom_addr    (rom_addr),
        .seq_num     (seq_num),
        .load        (load),
        .at_end      (at_end),
        .playing     (playing)
    );

    always #5 CLK_50 = ~CLK_50;

    // Directory RAM with one-cycle read latency.
    always @(posedge CLK_50) dir_rd_data <= dir_mem[dir_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ent(input logic v, input int s, input int l);
        return {v, 11'd0, 10'(l), 10'(s)};
    endfunction

    // Scoreboard side: every load must match the oldest queued expectation.
    always @(negedge CLK_50) begin
        if (!reset && load) begin
            load_cnt++;
            if (sb.size() == 0) chk("unexpected_load", 32'(rom_addr), 32'h7fff_ffff);
            else                chk("load_at_end_addr", 32'({at_end, rom_addr}), 32'(sb.pop_front()));
        end
    end

    task automatic exp_load(input logic e, input int a);
        sb.push_back({e, 10'(a)});
    endtask

    task automatic tick();
        @(negedge CLK_50) step_tick = 1'b1;
        @(negedge CLK_50) step_tick = 1'b0;
        repeat (2) @(negedge CLK_50);
    endtask

    task automatic press(input logic up, input logic dn);
        @(negedge CLK_50);
        pb_seq_up = up;
        pb_seq_dn = dn;
        repeat (PB + 2) @(negedge CLK_50);
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        repeat (PB + 2) @(negedge CLK_50);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) dir_mem[i] = 32'd0;
        dir_mem[0]  = ent(1'b1, 100, 3);
        dir_mem[1]  = ent(1'b0, 5, 3);
        dir_mem[2]  = ent(1'b1, 40, 0);
        dir_mem[3]  = ent(1'b1, 300, 2);
        dir_mem[4]  = ent(1'b1, 700, 3);
        dir_mem[63] = ent(1'b1, 500, 2);
        reset = 1'b1; pb_seq_up = 1'b0; pb_seq_dn = 1'b0; step_tick = 1'b0;
        repeat (3) @(negedge CLK_50);

        // Reset state
        chk("rst_seq_num", 32'(seq_num), 0);
        chk("rst_dir_addr", 32'(dir_rd_addr), 0);
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_load", 32'(load), 0);
        chk("rst_at_end", 32'(at_end), 0);
        chk("rst_playing", 32'(playing), 0);

        // Autostart on entry 0: first load after edge 2, then 101,102,100(end)
        exp_load(1'b0, 100); exp_load(1'b0, 101); exp_load(1'b0, 102); exp_load(1'b1, 100);
        snap = load_cnt;
        reset = 1'b0;
        @(negedge CLK_50);
        chk("autostart_load_e1", 32'(load), 0);
        @(negedge CLK_50);
        chk("autostart_load_e2", 32'(load), 1);
        chk("autostart_addr", 32'(rom_addr), 100);
        chk("autostart_playing", 32'(playing), 1);
        repeat (3) tick();
        chk("entry0_load_count", 32'(load_cnt - snap), 4);

        // Down from 0 wraps to 63; exact synchronizer latency
        exp_load(1'b0, 500);
        @(negedge CLK_50) pb_seq_dn = 1'b1;
        repeat (PB) @(negedge CLK_50);
        chk("dn_seq_before", 32'(seq_num), 0);
        @(negedge CLK_50);
        chk("dn_seq_after", 32'(seq_num), 63);
        chk("dn_dir_addr", 32'(dir_rd_addr), 63);
        chk("dn_playing_fetch", 32'(playing), 0);
        pb_seq_dn = 1'b0;
        repeat (6) @(negedge CLK_50);
        chk("dn_playing", 32'(playing), 1);
        exp_load(1'b0, 501); tick();
        exp_load(1'b1, 500); tick();

        // Both buttons together: no change, no refetch
        snap = load_cnt;
        press(1'b1, 1'b1);
        chk("both_seq", 32'(seq_num), 63);
        chk("both_no_load", 32'(load_cnt - snap), 0);
        chk("both_playing", 32'(playing), 1);

        // Up from 63 wraps to 0; entry 0 rewritten to wrap past 1023
        dir_mem[0] = ent(1'b1, 1022, 4);
        exp_load(1'b0, 1022);
        press(1'b1, 1'b0);
        chk("up_seq_wrap", 32'(seq_num), 0);
        exp_load(1'b0, 1023); tick();
        exp_load(1'b0, 0);    tick();
        exp_load(1'b0, 1);    tick();
        exp_load(1'b1, 1022); tick();

        // Invalid entry then zero-length entry: HALT ignores ticks
        snap = load_cnt;
        press(1'b1, 1'b0);
        chk("halt_invalid_seq", 32'(seq_num), 1);
        chk("halt_invalid_playing", 32'(playing), 0);
        repeat (100) begin
            @(negedge CLK_50) step_tick = 1'b1;
            @(negedge CLK_50) step_tick = 1'b0;
        end
        press(1'b1, 1'b0);
        chk("halt_len0_playing", 32'(playing), 0);
        chk("halt_no_loads", 32'(load_cnt - snap), 0);
        exp_load(1'b0, 300);
        press(1'b1, 1'b0);
        chk("after_halt_playing", 32'(playing), 1);
        exp_load(1'b0, 301); tick();

        // Press coinciding with step_tick: tick dropped, restart at 700
        exp_load(1'b0, 700);
        @(negedge CLK_50) pb_seq_up = 1'b1;
        @(negedge CLK_50);
        @(negedge CLK_50) step_tick = 1'b1;
        @(negedge CLK_50) step_tick = 1'b0;
        chk("coinc_seq", 32'(seq_num), 4);
        chk("coinc_addr_e", 32'(rom_addr), 301);
        @(negedge CLK_50);
        chk("coinc_addr_e1", 32'(rom_addr), 301);
        chk("coinc_load_e1", 32'(load), 0);
        @(negedge CLK_50);
        chk("coinc_addr_e2", 32'(rom_addr), 700);
        chk("coinc_load_e2", 32'(load), 1);
        pb_seq_up = 1'b0;
        repeat (4) @(negedge CLK_50);
        exp_load(1'b0, 701); tick();
        exp_load(1'b0, 702); tick();
        exp_load(1'b1, 700); tick();
        exp_load(1'b0, 701); tick();
        chk("queue_empty_pre_reset", 32'(sb.size()), 0);

        // Asynchronous reset mid-PLAY, then replay entry 0
        @(negedge CLK_50);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_addr", 32'(rom_addr), 0);
        chk("async_rst_seq", 32'(seq_num), 0);
        chk("async_rst_playing", 32'(playing), 0);
        chk("async_rst_load", 32'(load), 0);
        exp_load(1'b0, 1022);
        @(negedge CLK_50) reset = 1'b0;
        repeat (3) @(negedge CLK_50);
        chk("replay_playing", 32'(playing), 1);
        exp_load(1'b0, 1023); tick();
        exp_load(1'b0, 0);    tick();
        repeat (4) @(negedge CLK_50);
        chk("queue_empty_end", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_playback_ctrl.md
SEQ_PLAYBACK_CTRL -- requirements
Module: seq_playback_ctrl

Interface
REQ-001 Parameter: PB_SYNC_STAGES, default 2, number of synchronizer flops on each pushbutton input (legal range 2..4).
REQ-002 CLK_50  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 pb_seq_up  in  1  raw asynchronous pushbutton level, select next sequence.
REQ-005 pb_seq_dn  in  1  raw asynchronous pushbutton level, select previous sequence.
REQ-006 step_tick  in  1  single-cycle step-rate enable, synchronous to CLK_50.
REQ-007 dir_rd_addr  out  6  directory RAM read address.
REQ-008 dir_rd_data  in  32  directory entry; [9:0] start address, [19:10] length, [31] valid; read latency 1 cycle.
REQ-009 rom_addr  out  10  pattern ROM address of the current step.
REQ-010 seq_num  out  6  currently selected sequence index.
REQ-011 load  out  1  one-cycle pulse; rom_addr holds a new step this cycle.
REQ-012 at_end  out  1  one-cycle pulse coincident with the load that wraps back to start.
REQ-013 playing  out  1  high while state is PLAY.

Function
REQ-014 Each pushbutton SHALL pass through PB_SYNC_STAGES flops, then a rising-edge detector yielding a one-cycle event.
REQ-015 seq_num SHALL update exactly PB_SYNC_STAGES+1 rising edges after the first edge sampling the raw button high.
REQ-016 Up event alone: seq_num+1 mod 64 (63->0); down event alone: seq_num-1 mod 64 (0->63); both in same cycle: no change, no refetch.
REQ-017 dir_rd_addr SHALL equal seq_num combinationally at all times.
REQ-018 FSM states: FETCH, LATCH, PLAY, HALT; encoding is free.
REQ-019 FETCH SHALL last exactly one cycle, then go to LATCH.
REQ-020 LATCH SHALL sample dir_rd_data into start/length/valid registers.
REQ-021 In LATCH, if valid=0 or length=0: go to HALT; rom_addr unchanged, no load.
REQ-022 Otherwise LATCH SHALL set rom_addr=start, step count=0, assert load for the next cycle, go to PLAY.
REQ-023 In PLAY with step_tick=1 and step count < length-1: rom_addr+1 mod 1024, step count+1, load=1.
REQ-024 In PLAY with step_tick=1 and step count = length-1: rom_addr=start, step count=0, load=1, at_end=1.
REQ-025 In PLAY with step_tick=0: rom_addr, step count held; load=0, at_end=0.
REQ-026 Address wrap past 1023 SHALL roll to 0 with no error (start+length may exceed 1024).
REQ-027 HALT SHALL issue no load/at_end and wait for a seq_num change.
REQ-028 Any seq_num change SHALL force FETCH on the same edge from any state, aborting playback; step_tick that cycle is ignored.
REQ-029 step_tick SHALL be ignored in FETCH, LATCH and HALT.
REQ-030 Latency: seq_num change at edge E -> load and new rom_addr visible in the cycle following edge E+2.
REQ-031 load and at_end SHALL be registered outputs, never high for more than one consecutive cycle unless step_tick is high on consecutive PLAY cycles.

Reset
REQ-032 While reset=1: seq_num=0, rom_addr=0, load=0, at_end=0, playing=0, step count=0, synchronizers/edge detectors cleared, state=FETCH.
REQ-033 After reset release, the block SHALL fetch entry 0 and start playing without any button event (first load after edge 2).
REQ-034 Reset asserted mid-PLAY SHALL clear all outputs asynchronously, within the same cycle.

Verification
REQ-035 Entry0={valid,start=100,len=3}, reset release, tick every 4 cycles -> rom_addr 100,101,102,100; at_end only on 100 after 102; load count 4.
REQ-036 seq_num=0, one pb_seq_dn press -> seq_num=63 after PB_SYNC_STAGES+1 edges, dir_rd_addr=63, refetch; both buttons rising same cycle -> seq_num unchanged.
REQ-037 Entry={valid,start=1022,len=4} -> rom_addr 1022,1023,0,1, then 1022 with at_end.
REQ-038 Entry valid=0 or len=0 -> HALT, playing=0, no load for 100 ticks; pb_seq_up press -> next entry fetched and plays.
REQ-039 Button press mid-PLAY coincident with step_tick -> tick ignored, rom_addr jumps to new start 2 cycles after seq_num change, step count restarted.
REQ-040 reset pulse mid-PLAY -> all outputs 0 immediately; replay of entry 0 from its start after release.
